spi_cfg_regfile: RTL and testbench

//  SPI (mode 0, write-only) slave that loads the five 8-bit control registers driving pwm_peripheral.

---
 rtl/spi_regs_pkg.sv | 24 ++
 rtl/spi_cfg_regfile_if.sv | 27 ++
 rtl/sync_edge_detect.sv | 34 +++
 rtl/spi_cfg_regfile.sv | 136 +++++++++++++
 tb/tb_spi_cfg_regfile.sv | 162 ++++++++++++++++
 5 files changed

// File: rtl/spi_regs_pkg.sv
// Shared constants for the SPI configuration register file:
// register addresses, frame size, reset value and FSM state encoding.
package spi_regs_pkg;

  localparam logic [6:0] ADDR_EN_OUT_LO = 7'h00;
  localparam logic [6:0] ADDR_EN_OUT_HI = 7'h01;
  localparam logic [6:0] ADDR_EN_PWM_LO = 7'h02;
  localparam logic [6:0] ADDR_EN_PWM_HI = 7'h03;
  localparam logic [6:0] ADDR_DUTY      = 7'h04;

  localparam int         FRAME_BITS = 16;
  localparam logic [7:0] REG_RST    = 8'h00;

  // state  | meaning
  // IDLE   | waiting for nCS low, bit count held at zero
  // SHIFT  | frame in progress, sampling COPI on SCLK rises
  // COMMIT | one cycle: decode the frame and write / flag an error
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } state_t;

endpackage

// File: rtl/spi_cfg_regfile_if.sv
// Pin-side SPI signals plus the register outputs feeding pwm_peripheral.
interface spi_cfg_regfile_if;

  logic       sclk;
  logic       copi;
  logic       ncs;
  logic [7:0] en_reg_out_7_0;
  logic [7:0] en_reg_out_15_8;
  logic [7:0] en_reg_pwm_7_0;
  logic [7:0] en_reg_pwm_15_8;
  logic [7:0] pwm_duty_cycle;
  logic       wr_stb;
  logic       frame_err;

  modport slave (
    input  sclk, copi, ncs,
    output en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8,
           pwm_duty_cycle, wr_stb, frame_err
  );

  modport master (
    output sclk, copi, ncs,
    input  en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8,
           pwm_duty_cycle, wr_stb, frame_err
  );

endinterface

// File: rtl/sync_edge_detect.sv
// Multi-flop synchroniser for an asynchronous pin with rise/fall detection.
// RST_VAL lets idle-high pins (nCS) reset to their idle level so no false
// edge is seen when reset releases.
module sync_edge_detect #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RST_VAL     = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_dly;

  // Synchroniser chain plus one delayed copy of the last stage for edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync <= {SYNC_STAGES{RST_VAL}};
      r_dly  <= RST_VAL;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
      r_dly  <= r_sync[SYNC_STAGES-1];
    end
  end

  assign o_level = r_sync[SYNC_STAGES-1];
  assign o_rise  = r_sync[SYNC_STAGES-1] & ~r_dly;
  assign o_fall  = ~r_sync[SYNC_STAGES-1] & r_dly;

endmodule

// File: rtl/spi_cfg_regfile.sv
// Write-only SPI mode-0 slave loading the five pwm_peripheral control
// registers. Frame = R/W bit, 7-bit address, 8-bit data, MSB first; the
// write is committed when nCS rises.
module spi_cfg_regfile #(
  parameter int SYNC_STAGES = 2,
  parameter int FRAME_BITS  = spi_regs_pkg::FRAME_BITS,
  parameter int MAX_ADDR    = 4
) (
  input logic            clk,
  input logic            rst,
  spi_cfg_regfile_if.slave bus
);

  import spi_regs_pkg::*;

  localparam int              CNT_W    = $clog2(FRAME_BITS + 2);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BITS);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(FRAME_BITS + 1);

  logic w_sclk_lvl, w_sclk_rise, w_sclk_fall;
  logic w_copi_lvl, w_copi_rise, w_copi_fall;
  logic w_ncs_lvl,  w_ncs_rise,  w_ncs_fall;
  logic w_unused_edges;

  state_t                r_state, w_state_nxt;
  logic [FRAME_BITS-1:0] r_shift;
  logic [CNT_W-1:0]      r_cnt;

  logic       w_rw;
  logic [6:0] w_addr;
  logic [7:0] w_data;
  logic       w_wr_en;
  logic       w_err;

  logic [7:0] r_en_out_lo, r_en_out_hi, r_en_pwm_lo, r_en_pwm_hi, r_duty;
  logic       r_wr_stb, r_frame_err;

  sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .rst(rst), .i_d(bus.sclk),
    .o_level(w_sclk_lvl), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall)
  );

  sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_copi (
    .clk(clk), .rst(rst), .i_d(bus.copi),
    .o_level(w_copi_lvl), .o_rise(w_copi_rise), .o_fall(w_copi_fall)
  );

  sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ncs (
    .clk(clk), .rst(rst), .i_d(bus.ncs),
    .o_level(w_ncs_lvl), .o_rise(w_ncs_rise), .o_fall(w_ncs_fall)
  );

  // Edge outputs this block has no use for
  assign w_unused_edges = w_sclk_lvl ^ w_sclk_fall ^ w_copi_rise ^ w_copi_fall ^ w_ncs_fall;

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // FSM next-state logic; nCS is level-tested in IDLE so a fall during COMMIT is not missed
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (!w_ncs_lvl) w_state_nxt = SHIFT;
      SHIFT:   if (w_ncs_rise) w_state_nxt = COMMIT;
      COMMIT:  w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Shift register and saturating bit counter; a SCLK rise coinciding with nCS rise is dropped
  always_ff @(posedge clk) begin
    if (rst) begin
      r_shift <= '0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_shift <= '0;
          r_cnt   <= '0;
        end
        SHIFT: begin
          if (w_sclk_rise && !w_ncs_lvl) begin
            r_shift <= {r_shift[FRAME_BITS-2:0], w_copi_lvl};
            if (r_cnt != CNT_SAT) r_cnt <= r_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign w_rw    = r_shift[FRAME_BITS-1];
  assign w_addr  = r_shift[FRAME_BITS-2 -: 7];
  assign w_data  = r_shift[7:0];
  assign w_wr_en = (r_state == COMMIT) && (r_cnt == CNT_FULL) && w_rw &&
                   (w_addr <= 7'(MAX_ADDR));
  assign w_err   = (r_state == COMMIT) && (r_cnt != CNT_FULL);

  // Register bank and status pulses, updated on the edge that ends COMMIT
  always_ff @(posedge clk) begin
    if (rst) begin
      r_en_out_lo <= REG_RST;
      r_en_out_hi <= REG_RST;
      r_en_pwm_lo <= REG_RST;
      r_en_pwm_hi <= REG_RST;
      r_duty      <= REG_RST;
      r_wr_stb    <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_wr_stb    <= w_wr_en;
      r_frame_err <= w_err;
      if (w_wr_en) begin
        case (w_addr)
          ADDR_EN_OUT_LO: r_en_out_lo <= w_data;
          ADDR_EN_OUT_HI: r_en_out_hi <= w_data;
          ADDR_EN_PWM_LO: r_en_pwm_lo <= w_data;
          ADDR_EN_PWM_HI: r_en_pwm_hi <= w_data;
          ADDR_DUTY:      r_duty      <= w_data;
          default: ;
        endcase
      end
    end
  end

  assign bus.en_reg_out_7_0  = r_en_out_lo;
  assign bus.en_reg_out_15_8 = r_en_out_hi;
  assign bus.en_reg_pwm_7_0  = r_en_pwm_lo;
  assign bus.en_reg_pwm_15_8 = r_en_pwm_hi;
  assign bus.pwm_duty_cycle  = r_duty;
  assign bus.wr_stb          = r_wr_stb;
  assign bus.frame_err       = r_frame_err;

endmodule

// File: tb/tb_spi_cfg_regfile.sv
// Directed bench for spi_cfg_regfile: table of single frames plus
// sequences for latency, back-to-back frames and reset mid-frame.
module tb_spi_cfg_regfile;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_err = 0;
  int   n_wr_pulse = 0;
  int   n_err_pulse = 0;

  spi_cfg_regfile_if bus ();

  spi_cfg_regfile #(.SYNC_STAGES(2), .FRAME_BITS(16), .MAX_ADDR(4)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  always #5 clk = ~clk;

  // Count status pulses away from the active edge
  always @(negedge clk) begin
    if (bus.wr_stb)    n_wr_pulse++;
    if (bus.frame_err) n_err_pulse++;
  end

  typedef struct {
    logic [31:0] frame;
    int          nbits;
    logic [7:0]  e0, e1, e2, e3, e4;
    int          ewr;
    int          eerr;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic spi_bits(input logic [31:0] data, input int nbits);
    bus.ncs = 1'b0;
    wait_clks(4);
    for (int i = nbits - 1; i >= 0; i--) begin
      bus.copi = data[i];
      wait_clks(4);
      bus.sclk = 1'b1;
      wait_clks(4);
      bus.sclk = 1'b0;
    end
    wait_clks(4);
  endtask

  task automatic spi_frame(input logic [31:0] data, input int nbits, input int gap);
    spi_bits(data, nbits);
    bus.ncs = 1'b1;
    wait_clks(gap);
  endtask

  task automatic chk_regs(input string tag, input logic [7:0] e0, input logic [7:0] e1,
                          input logic [7:0] e2, input logic [7:0] e3, input logic [7:0] e4);
    chk({tag, " out_7_0"},  bus.en_reg_out_7_0,  e0);
    chk({tag, " out_15_8"}, bus.en_reg_out_15_8, e1);
    chk({tag, " pwm_7_0"},  bus.en_reg_pwm_7_0,  e2);
    chk({tag, " pwm_15_8"}, bus.en_reg_pwm_15_8, e3);
    chk({tag, " duty"},     bus.pwm_duty_cycle,  e4);
  endtask

  initial begin
    int wr0, err0, k;
    logic [15:0] f6;

    vecs[0] = '{32'h0000_8455, 16, 8'h00, 8'h00, 8'h00, 8'h00, 8'h55, 1, 0};
    vecs[1] = '{32'h0000_0433, 16, 8'h00, 8'h00, 8'h00, 8'h00, 8'h55, 0, 0};
    vecs[2] = '{32'h0000_8733, 16, 8'h00, 8'h00, 8'h00, 8'h00, 8'h55, 0, 0};
    vecs[3] = '{32'h0000_0845, 12, 8'h00, 8'h00, 8'h00, 8'h00, 8'h55, 0, 1};
    vecs[4] = '{32'h0008_4566, 20, 8'h00, 8'h00, 8'h00, 8'h00, 8'h55, 0, 1};
    vecs[5] = '{32'h0000_84A5, 16, 8'h00, 8'h00, 8'h00, 8'h00, 8'hA5, 1, 0};

    bus.sclk = 1'b0;
    bus.copi = 1'b0;
    bus.ncs  = 1'b1;
    rst      = 1'b1;
    wait_clks(2);
    rst = 1'b0;
    wait_clks(4);

    chk_regs("reset", 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    chk("reset wr_stb", bus.wr_stb, 1'b0);
    chk("reset frame_err", bus.frame_err, 1'b0);

    for (int v = 0; v < 6; v++) begin
      wr0  = n_wr_pulse;
      err0 = n_err_pulse;
      spi_frame(vecs[v].frame, vecs[v].nbits, 12);
      chk_regs($sformatf("vec%0d", v), vecs[v].e0, vecs[v].e1, vecs[v].e2, vecs[v].e3, vecs[v].e4);
      chk($sformatf("vec%0d wr_pulses", v), n_wr_pulse - wr0, vecs[v].ewr);
      chk($sformatf("vec%0d err_pulses", v), n_err_pulse - err0, vecs[v].eerr);
    end

    // Commit latency: wr_stb rises SYNC_STAGES+2 edges after nCS pin rises
    spi_bits(32'h0000_813C, 16);
    bus.ncs = 1'b1;
    k = 0;
    while (k < 20) begin
      @(posedge clk);
      #1;
      k++;
      if (bus.wr_stb) break;
    end
    chk("commit latency", k, 4);
    wait_clks(8);
    chk("latency out_15_8", bus.en_reg_out_15_8, 8'h3C);

    // Back-to-back frames with nCS high for one SCLK period
    wr0 = n_wr_pulse;
    spi_frame(32'h0000_80F0, 16, 8);
    spi_frame(32'h0000_810F, 16, 8);
    spi_frame(32'h0000_82AA, 16, 8);
    spi_frame(32'h0000_8301, 16, 12);
    chk_regs("b2b", 8'hF0, 8'h0F, 8'hAA, 8'h01, 8'hA5);
    chk("b2b wr_pulses", n_wr_pulse - wr0, 4);

    // Reset after bit 9 of 0x8299, then a clean 0x8299
    f6   = 16'h8299;
    err0 = n_err_pulse;
    bus.ncs = 1'b0;
    wait_clks(4);
    for (int i = 15; i >= 7; i--) begin
      bus.copi = f6[i];
      wait_clks(4);
      bus.sclk = 1'b1;
      wait_clks(4);
      bus.sclk = 1'b0;
    end
    wait_clks(2);
    rst = 1'b1;
    wait_clks(2);
    bus.ncs = 1'b1;
    wait_clks(4);
    rst = 1'b0;
    wait_clks(6);
    chk_regs("midrst", 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    chk("midrst err_pulses", n_err_pulse - err0, 0);
    wr0 = n_wr_pulse;
    spi_frame({16'h0000, f6}, 16, 12);
    chk_regs("after_rst", 8'h00, 8'h00, 8'h99, 8'h00, 8'h00);
    chk("after_rst wr_pulses", n_wr_pulse - wr0, 1);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
